// File: rtl/pythag_classifier.sv
// rtl/pythag_classifier.sv - classifies a side-length triple as right/acute/obtuse/degenerate
// Squares come from one shared shift-add multiplier, so latency is fixed at 3W+1 cycles.
module pythag_classifier #(
  parameter int W       = 5,
  parameter int SORT_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W-1:0]       c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         cls,
  output logic               is_right,
  output logic [2*W:0]       sum_sq,
  output logic [2*W-1:0]     hyp_sq,
  output logic [CNT_W-1:0]   n_total,
  output logic [CNT_W-1:0]   n_right
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SQ_X = 3'd1;
  localparam logic [2:0] SQ_Y = 3'd2;
  localparam logic [2:0] SQ_Z = 3'd3;
  localparam logic [2:0] CMP  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W:0]     sum_acc_q, sum_acc_d;
  logic [2*W-1:0]   zsq_q, zsq_d;
  logic [1:0]       cls_q, cls_d;
  logic             is_right_q, is_right_d;
  logic [2*W:0]     sum_sq_q, sum_sq_d;
  logic [2*W-1:0]   hyp_sq_q, hyp_sq_d;
  logic [CNT_W-1:0] n_total_q, n_total_d, n_right_q, n_right_d;

  logic [W-1:0]     op;
  logic [2*W-1:0]   partial;
  logic [2*W-1:0]   acc_nxt;
  logic             last_bit;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    bit_d      = bit_q;
    acc_d      = acc_q;
    sum_acc_d  = sum_acc_q;
    zsq_d      = zsq_q;
    cls_d      = cls_q;
    is_right_d = is_right_q;
    sum_sq_d   = sum_sq_q;
    hyp_sq_d   = hyp_sq_q;
    n_total_d  = n_total_q;
    n_right_d  = n_right_q;

    // Multiplicand and multiplier are the same operand: op * op, one bit of op per cycle.
    case (state_q)
      SQ_Y:    op = y_q;
      SQ_Z:    op = z_q;
      default: op = x_q;
    endcase
    partial  = op[bit_q] ? ({{W{1'b0}}, op} << bit_q) : '0;
    acc_nxt  = acc_q + partial;
    last_bit = (bit_q == BW'(W - 1));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (SORT_EN != 0) begin
            // Ties go to the later input, so c wins over a/b and b wins over a.
            if (c >= a && c >= b) begin
              x_d = a; y_d = b; z_d = c;
            end else if (b >= a) begin
              x_d = a; y_d = c; z_d = b;
            end else begin
              x_d = b; y_d = c; z_d = a;
            end
          end else begin
            x_d = a; y_d = b; z_d = c;
          end
          acc_d   = '0;
          bit_d   = '0;
          state_d = SQ_X;
        end
      end
      SQ_X, SQ_Y, SQ_Z: begin
        acc_d = acc_nxt;
        bit_d = bit_q + BW'(1);
        if (last_bit) begin
          acc_d = '0;
          bit_d = '0;
          if (state_q == SQ_X) begin
            sum_acc_d = {1'b0, acc_nxt};
            state_d   = SQ_Y;
          end else if (state_q == SQ_Y) begin
            sum_acc_d = sum_acc_q + {1'b0, acc_nxt};
            state_d   = SQ_Z;
          end else begin
            zsq_d   = acc_nxt;
            state_d = CMP;
          end
        end
      end
      CMP: begin
        sum_sq_d = sum_acc_q;
        hyp_sq_d = zsq_q;
        if (x_q == '0 || y_q == '0 || z_q == '0) begin
          cls_d = 2'b11;
        end else if (sum_acc_q == {1'b0, zsq_q}) begin
          cls_d = 2'b00;
        end else if (sum_acc_q > {1'b0, zsq_q}) begin
          cls_d = 2'b01;
        end else begin
          cls_d = 2'b10;
        end
        is_right_d = (cls_d == 2'b00);
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (n_total_q != '1) n_total_d = n_total_q + CNT_W'(1);
          if (cls_q == 2'b00 && n_right_q != '1) n_right_d = n_right_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      bit_q      <= '0;
      acc_q      <= '0;
      sum_acc_q  <= '0;
      zsq_q      <= '0;
      cls_q      <= 2'b00;
      is_right_q <= 1'b0;
      sum_sq_q   <= '0;
      hyp_sq_q   <= '0;
      n_total_q  <= '0;
      n_right_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      bit_q      <= bit_d;
      acc_q      <= acc_d;
      sum_acc_q  <= sum_acc_d;
      zsq_q      <= zsq_d;
      cls_q      <= cls_d;
      is_right_q <= is_right_d;
      sum_sq_q   <= sum_sq_d;
      hyp_sq_q   <= hyp_sq_d;
      n_total_q  <= n_total_d;
      n_right_q  <= n_right_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign cls       = cls_q;
  assign is_right  = is_right_q;
  assign sum_sq    = sum_sq_q;
  assign hyp_sq    = hyp_sq_q;
  assign n_total   = n_total_q;
  assign n_right   = n_right_q;

endmodule

// File: tb/tb_pythag_classifier.sv
// tb/tb_pythag_classifier.sv - scoreboard bench for pythag_classifier
// dut0: sorted, wide counters; dut1: unsorted, 2-bit saturating counters; both share stimulus.
module tb_pythag_classifier;

  typedef struct {
    logic [1:0]  cls;
    logic [10:0] sum;
    logic [9:0]  hyp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  a = '0, b = '0, c = '0;

  logic        in_ready0, out_valid0, is_right0;
  logic [1:0]  cls0;
  logic [10:0] sum_sq0;
  logic [9:0]  hyp_sq0;
  logic [15:0] n_total0, n_right0;

  logic        in_ready1, out_valid1, is_right1;
  logic [1:0]  cls1;
  logic [10:0] sum_sq1;
  logic [9:0]  hyp_sq1;
  logic [1:0]  n_total1, n_right1;

  int errors = 0;
  int checks = 0;
  int m_tot0 = 0, m_right0 = 0, m_tot1 = 0, m_right1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  pythag_classifier #(.W(5), .SORT_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .out_valid(out_valid0), .out_ready(out_ready),
    .cls(cls0), .is_right(is_right0), .sum_sq(sum_sq0), .hyp_sq(hyp_sq0),
    .n_total(n_total0), .n_right(n_right0)
  );

  pythag_classifier #(.W(5), .SORT_EN(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c(c), .out_valid(out_valid1), .out_ready(out_ready),
    .cls(cls1), .is_right(is_right1), .sum_sq(sum_sq1), .hyp_sq(hyp_sq1),
    .n_total(n_total1), .n_right(n_right1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] ia, ib, ic, input bit sort);
    exp_t e;
    int x, y, z, s, h;
    x = ia; y = ib; z = ic;
    if (sort) begin
      if (ic >= ia && ic >= ib) begin x = ia; y = ib; z = ic; end
      else if (ib >= ia)        begin x = ia; y = ic; z = ib; end
      else                      begin x = ib; y = ic; z = ia; end
    end
    s = x * x + y * y;
    h = z * z;
    if (x == 0 || y == 0 || z == 0) e.cls = 2'b11;
    else if (s == h)                e.cls = 2'b00;
    else if (s > h)                 e.cls = 2'b01;
    else                            e.cls = 2'b10;
    e.sum = 11'(s);
    e.hyp = 10'(h);
    return e;
  endfunction

  task automatic capture(input logic [4:0] ia, ib, ic);
    int n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 1, 0);
    a = ia; b = ib; c = ic;
    in_valid = 1'b1;
    @(posedge clk);
    q0.push_back(model(ia, ib, ic, 1'b1));
    q1.push_back(model(ia, ib, ic, 1'b0));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int lat = 0;
    while (!out_valid0 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, 16);
    chk("valid_pair", out_valid1, 1);
  endtask

  task automatic deliver(input int stall);
    exp_t e0, e1;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = 5'd1; b = 5'd1; c = 5'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (stall > 0) begin
      chk("held_valid", out_valid0, 1);
      chk("busy_ready", in_ready0, 0);
    end
    if (q0.size() == 0 || q1.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("cls0", cls0, e0.cls);
    chk("is_right0", is_right0, e0.cls == 2'b00);
    chk("sum_sq0", sum_sq0, e0.sum);
    chk("hyp_sq0", hyp_sq0, e0.hyp);
    chk("cls1", cls1, e1.cls);
    chk("is_right1", is_right1, e1.cls == 2'b00);
    chk("sum_sq1", sum_sq1, e1.sum);
    chk("hyp_sq1", hyp_sq1, e1.hyp);
    out_ready = 1'b1;
    @(posedge clk);
    m_tot0++;
    if (e0.cls == 2'b00) m_right0++;
    if (m_tot1 < 3) m_tot1++;
    if (e1.cls == 2'b00 && m_right1 < 3) m_right1++;
    #1;
    chk("n_total0", n_total0, m_tot0);
    chk("n_right0", n_right0, m_right0);
    chk("n_total1", n_total1, m_tot1);
    chk("n_right1", n_right1, m_right1);
    chk("idle_ready", in_ready0, 1);
    chk("idle_valid", out_valid0, 0);
  endtask

  task automatic run(input logic [4:0] ia, ib, ic, input int stall);
    out_ready = (stall == 0);
    capture(ia, ib, ic);
    wait_out();
    deliver(stall);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, in_ready0, 1);
    chk({tag, "_valid"}, out_valid0, 0);
    chk({tag, "_cls"}, cls0, 0);
    chk({tag, "_isr"}, is_right0, 0);
    chk({tag, "_sum"}, sum_sq0, 0);
    chk({tag, "_hyp"}, hyp_sq0, 0);
    chk({tag, "_ntot"}, n_total0, m_tot0);
    chk({tag, "_nright"}, n_right0, m_right0);
    chk({tag, "_ntot1"}, n_total1, m_tot1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cleared("reset");

    out_ready = 1'b1;
    capture(5'd3, 5'd4, 5'd5);
    repeat (7) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    chk_cleared("rst_sqy");

    out_ready = 1'b0;
    capture(5'd3, 5'd4, 5'd5);
    wait_out();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); q1.delete();
    chk_cleared("rst_done");

    run(5'd3, 5'd4, 5'd5, 0);
    run(5'd5, 5'd3, 5'd4, 0);
    run(5'd2, 5'd3, 5'd4, 0);
    run(5'd0, 5'd4, 5'd4, 0);
    run(5'd31, 5'd31, 5'd31, 0);
    run(5'd6, 5'd8, 5'd10, 20);
    run(5'd8, 5'd6, 5'd10, 0);
    run(5'd5, 5'd12, 5'd13, 0);
    run(5'd4, 5'd4, 5'd1, 0);
    for (int i = 0; i < 6; i++) begin
      run(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), i % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pythag_classifier.md
PYTHAG_CLASSIFIER -- requirements
Module: pythag_classifier

Interface
REQ-001 SHALL have parameter W, default 5: unsigned side-length width, legal range 2..16.
REQ-002 SHALL have parameter SORT_EN, default 1: when 1, the largest side is treated as hypotenuse; when 0, input c is always the hypotenuse.
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  triple on a/b/c is valid.
REQ-007 in_ready  output  1  block can accept a triple.
REQ-008 a, b, c  input  W each  unsigned side lengths.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 cls  output  2  class: 00 right, 01 acute, 10 obtuse, 11 degenerate.
REQ-012 is_right  output  1  1 iff cls==00.
REQ-013 sum_sq  output  2W+1  x^2+y^2 of the two legs.
REQ-014 hyp_sq  output  2W  z^2 of the hypotenuse.
REQ-015 n_total, n_right  output  CNT_W each  count of results delivered; count of right results delivered.

Function
REQ-016 FSM states SHALL be IDLE, SQ_X, SQ_Y, SQ_Z, CMP, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a capture occurs on a rising edge where in_valid && in_ready.
REQ-018 On capture, SORT_EN=1: z = max(a,b,c); x, y = remaining two in input order (ties: the last maximal input in order a,b,c becomes z); SORT_EN=0: x=a, y=b, z=c. Transition IDLE->SQ_X.
REQ-019 Squares SHALL be computed by a single shared iterative shift-add multiplier, one multiplier bit per cycle, exactly W cycles per square; no combinational W x W multiply.
REQ-020 SQ_X, SQ_Y, SQ_Z SHALL each last exactly W cycles and then advance to the next state; SQ_Z advances to CMP.
REQ-021 CMP SHALL last 1 cycle: the 2W+1-bit sum of x^2 and y^2 is compared with zero-extended z^2 and cls is registered; transition CMP->DONE.
REQ-022 Classification: any of x,y,z ==0 -> 11; else sum==z^2 -> 00; sum>z^2 -> 01; sum<z^2 -> 10.
REQ-023 Degenerate triples SHALL take the full latency; latency is constant and data-independent.
REQ-024 out_valid SHALL be 1 exactly in DONE; it first becomes visible after the edge at capture edge + 3W+1 (W=5: 16 cycles).
REQ-025 cls, is_right, sum_sq, hyp_sq SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 On an edge with out_valid && out_ready: DONE->IDLE; n_total += 1; n_right += 1 if cls==00.
REQ-027 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-028 in_valid while busy SHALL be ignored; a/b/c changes after capture SHALL have no effect.
REQ-029 At most one triple SHALL be in flight; next capture no earlier than the edge after the DONE->IDLE handoff.

Reset
REQ-030 rst=1 on an edge SHALL force IDLE, in_ready=1, out_valid=0, cls=00, is_right=0, sum_sq=0, hyp_sq=0, n_total=0, n_right=0, multiplier state cleared.
REQ-031 rst SHALL take priority over every handshake in the same cycle; an in-flight or undelivered result SHALL be discarded and not counted.
REQ-032 First capture after reset SHALL be possible on the first edge with rst=0.

Verification
REQ-033 W=5, (a,b,c)=(3,4,5), out_ready=1 -> out_valid 16 cycles after capture, cls=00, is_right=1, sum_sq=25, hyp_sq=25, n_total=1, n_right=1.
REQ-034 (5,3,4): SORT_EN=1 -> cls=00, hyp_sq=25; SORT_EN=0 -> sum_sq=34, hyp_sq=16, cls=01.
REQ-035 (2,3,4) -> cls=10, sum_sq=13, hyp_sq=16; (0,4,4) -> cls=11 with latency still 16; (31,31,31) -> sum_sq=1922, hyp_sq=961, cls=01.
REQ-036 (6,8,10) with out_ready=0 for 20 cycles -> out_valid held, outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> one count only, IDLE next cycle.
REQ-037 rst pulsed mid-SQ_Y, then rst pulsed in DONE before out_ready -> all outputs zero, counters unchanged at 0, next (3,4,5) completes normally.
REQ-038 CNT_W=2, four right triples -> n_total=3, n_right=3 (saturated).
